// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                        |
// | Stall/flush/freeze sequencing for the PC, IF/ID, ID/EX, EX/MEM registers.   |
// | Optional macro: HAZARD_PERF_CNT_EN adds stallCount/flushCount outputs.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int REG_NUM_WIDTH = 5,
   parameter int FLUSH_CYCLES  = 1,
   parameter int MEM_TIMEOUT   = 15
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_WIDTH     = 16
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REG_NUM_WIDTH-1:0] idRS,
   input  logic [REG_NUM_WIDTH-1:0] idRT,
   input  logic                     idUsesRS,
   input  logic                     idUsesRT,
   input  logic                     exMemRead,
   input  logic [REG_NUM_WIDTH-1:0] exDcRT,
   input  logic                     branchTaken,
   input  logic                     memReq,
   input  logic                     memReady,
   output logic                     pcWrEn,
   output logic                     ifidWrEn,
   output logic                     ifidFlush,
   output logic                     idexWrEn,
   output logic                     idexBubble,
   output logic                     exmemWrEn,
   output logic                     memTimeout,
   output logic [1:0]               ctrlState
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]     stallCount,
   output logic [CNT_WIDTH-1:0]     flushCount
`endif
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int FLSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
   localparam logic [FLSH_W-1:0] FLUSH_LOAD = FLSH_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_FLUSH    = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_t;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [FLSH_W-1:0]   flush_cnt, flush_nxt;
   logic                timeout_set;
   logic                mem_stall, load_use;
   logic                pc_en, ifid_en, idex_en, exmem_en, flush_o, bubble_o;

   assign mem_stall = memReq & ~memReady;
   assign load_use  = exMemRead && (exDcRT != '0) &&
                      ((idUsesRS && (idRS == exDcRT)) || (idUsesRT && (idRT == exDcRT)));

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      flush_nxt   = flush_cnt;
      timeout_set = 1'b0;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      flush_o     = 1'b0;
      bubble_o    = 1'b0;
      if (mem_stall) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               state_nxt = ST_MEM_WAIT;
               wait_nxt  = WAIT_W'(1);
            end else if (branchTaken) begin
               flush_o  = 1'b1;
               bubble_o = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt = ST_FLUSH;
                  flush_nxt = FLUSH_LOAD;
               end
            end else if (load_use) begin
               pc_en    = 1'b0;
               ifid_en  = 1'b0;
               bubble_o = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (!mem_stall) begin
               flush_o  = 1'b1;
               bubble_o = 1'b1;
               if (flush_cnt == FLSH_W'(1)) begin
                  state_nxt = ST_RUN;
                  flush_nxt = '0;
               end else begin
                  flush_nxt = flush_cnt - 1'b1;
               end
            end
         end
         ST_MEM_WAIT: begin
            // Held stages re-evaluate hazards only once back in RUN.
            if (mem_stall) begin
               if (wait_cnt >= WAIT_MAX) begin
                  timeout_set = 1'b1;
                  state_nxt   = ST_RUN;
                  wait_nxt    = '0;
               end else begin
                  wait_nxt = wait_cnt + 1'b1;
               end
            end else begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            wait_nxt  = '0;
            flush_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RUN;
         wait_cnt   <= '0;
         flush_cnt  <= '0;
         memTimeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         flush_cnt <= flush_nxt;
         if (timeout_set) memTimeout <= 1'b1;
      end
   end

   // Reset forces every control low regardless of state.
   assign pcWrEn     = pc_en    & ~rst;
   assign ifidWrEn   = ifid_en  & ~rst;
   assign idexWrEn   = idex_en  & ~rst;
   assign exmemWrEn  = exmem_en & ~rst;
   assign ifidFlush  = flush_o  & ~rst;
   assign idexBubble = bubble_o & ~rst;
   assign ctrlState  = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (!pcWrEn && (stallCount != '1)) stallCount <= stallCount + 1'b1;
         if (ifidFlush && (flushCount != '1)) flushCount <= flushCount + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire
